// File: rtl/sync_fifo_mem_pkg.sv
// Shared definitions for the memories-subsystem FIFO: default geometry and access decoding.
// Optional error reporting in sync_fifo_mem is enabled with the SYNC_FIFO_ERR_EN macro.
package sync_fifo_mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } fifo_op_e;

  function automatic fifo_op_e op_of(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// DEPTH x DATA_W storage array: one synchronous write port on bclk, one read port, no reset.
// The read word is registered in sync_fifo_mem so it can be reset and held between pops.
module fifo_ram_dp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              bclk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge bclk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO on bclk with registered read data and registered full/empty/almost-full flags.
// Define SYNC_FIFO_ERR_EN to add sticky ovf_err/unf_err outputs.
module sync_fifo_mem
  import sync_fifo_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = 12,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic              bclk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
`ifdef SYNC_FIFO_ERR_EN
  output logic              ovf_err,
  output logic              unf_err,
`endif
  output logic [AW:0]       count
);

  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_AF    = (AW+1)'(AF_THRESH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [AW:0]       count_nxt_s;
  logic [DATA_W-1:0] rd_data_r;
  logic [DATA_W-1:0] ram_rdata_s;
  logic              rd_valid_r;
  logic              full_r;
  logic              empty_r;
  logic              almost_full_r;
  logic              push_s;
  logic              pop_s;
  fifo_op_e          op_s;

  // Accesses are qualified by the flags registered at the start of the cycle.
  assign push_s = wr_en & ~full_r;
  assign pop_s  = rd_en & ~empty_r;
  assign op_s   = op_of(push_s, pop_s);

  fifo_ram_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .bclk  (bclk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (wr_data),
    .raddr (rd_ptr_r),
    .rdata (ram_rdata_s)
  );

  // Next occupancy; flags are computed from it so they line up with count.
  always_comb begin
    count_nxt_s = count_r;
    case (op_s)
      OP_PUSH: count_nxt_s = count_r + CNT_ONE;
      OP_POP:  count_nxt_s = count_r - CNT_ONE;
      OP_BOTH: count_nxt_s = count_r;
      OP_IDLE: count_nxt_s = count_r;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, flags and the registered read word.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      rd_data_r     <= '0;
      rd_valid_r    <= 1'b0;
      full_r        <= 1'b0;
      empty_r       <= 1'b1;
      almost_full_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        rd_data_r <= ram_rdata_s;
      end
      rd_valid_r    <= pop_s;
      count_r       <= count_nxt_s;
      full_r        <= (count_nxt_s == CNT_FULL);
      empty_r       <= (count_nxt_s == '0);
      almost_full_r <= (count_nxt_s >= CNT_AF);
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_err_r;
  logic unf_err_r;

  // Sticky misuse flags; only the asynchronous reset clears them.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_r <= 1'b0;
      unf_err_r <= 1'b0;
    end else begin
      ovf_err_r <= ovf_err_r | (wr_en & full_r);
      unf_err_r <= unf_err_r | (rd_en & empty_r);
    end
  end

  assign ovf_err = ovf_err_r;
  assign unf_err = unf_err_r;
`endif

  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign almost_full = almost_full_r;
  assign count       = count_r;

endmodule

// File: tb/tb_sync_fifo_mem.sv
// Self-checking bench for sync_fifo_mem: directed phases plus random traffic against a queue model.
// Define SYNC_FIFO_ERR_EN for both RTL and bench to also check ovf_err/unf_err.
module tb_sync_fifo_mem;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int AF_THRESH = 12;
  localparam int AW        = 4;

  logic              bclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = 8'h00;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [AW:0]       count;
`ifdef SYNC_FIFO_ERR_EN
  logic              ovf_err;
  logic              unf_err;
  logic              exp_ovf = 1'b0;
  logic              exp_unf = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] exp_rd_data = 8'h00;
  logic              exp_rd_valid = 1'b0;

  always #5 bclk = ~bclk;

  sync_fifo_mem #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) dut (
    .bclk        (bclk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
`ifdef SYNC_FIFO_ERR_EN
    .ovf_err     (ovf_err),
    .unf_err     (unf_err),
`endif
    .count       (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF_THRESH));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_rd_valid));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd_data));
`ifdef SYNC_FIFO_ERR_EN
    chk({tag, ".ovf_err"}, 32'(ovf_err), 32'(exp_ovf));
    chk({tag, ".unf_err"}, 32'(unf_err), 32'(exp_unf));
`endif
  endtask

  // One clock of traffic: drive, clock, advance the model, compare.
  task automatic step(input string tag, input logic w, input logic r, input logic [DATA_W-1:0] d);
    bit was_full;
    bit was_empty;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    @(posedge bclk);
    #1;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    exp_rd_valid = 1'b0;
    if (r && !was_empty) begin
      exp_rd_data  = model_q.pop_front();
      exp_rd_valid = 1'b1;
    end
    if (w && !was_full) model_q.push_back(d);
`ifdef SYNC_FIFO_ERR_EN
    if (w && was_full) exp_ovf = 1'b1;
    if (r && was_empty) exp_unf = 1'b1;
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(tag);
  endtask

  initial begin
    // Reset held for three cycles.
    repeat (3) @(posedge bclk);
    #1;
    check_all("reset");
    #2 rst_n = 1'b1;

    // Fill 0x00..0x0F, then an overflowing write.
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, 1'b0, 8'(i));
      if (i == AF_THRESH - 2) chk("af_before_12", 32'(almost_full), 32'd0);
      if (i == AF_THRESH - 1) chk("af_at_12", 32'(almost_full), 32'd1);
    end
    chk("full_after_16", 32'(full), 32'd1);
    step("ovf", 1'b1, 1'b0, 8'hAA);
    chk("ovf_count", 32'(count), 32'd16);

    // Drain in order, then an underflowing read.
    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 1'b1, 8'h00);
      chk("drain_order", 32'(rd_data), 32'(i));
    end
    step("unf", 1'b0, 1'b1, 8'h00);
    chk("unf_valid", 32'(rd_valid), 32'd0);

    // Simultaneous push/pop at count 5 across the pointer wrap.
    for (int i = 0; i < 5; i++) step("wrap_pre", 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      step("wrap", 1'b1, 1'b1, 8'($urandom));
      chk("wrap_count", 32'(count), 32'd5);
    end
    while (model_q.size() < DEPTH) step("refill", 1'b1, 1'b0, 8'($urandom));

    // Full with both requests: only the pop happens.
    step("full_both", 1'b1, 1'b1, 8'hC3);
    chk("full_both_count", 32'(count), 32'd15);
    while (model_q.size() > 0) step("empty_out", 1'b0, 1'b1, 8'h00);

    // Empty with both requests: only the push happens, no fall-through.
    step("empty_both", 1'b1, 1'b1, 8'h3C);
    chk("empty_both_count", 32'(count), 32'd1);
    chk("empty_both_valid", 32'(rd_valid), 32'd0);
    step("empty_both_rd", 1'b0, 1'b1, 8'h00);
    chk("empty_both_data", 32'(rd_data), 32'h3C);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Mid-burst asynchronous reset at count 9.
    while (model_q.size() > 9) step("to9_dn", 1'b0, 1'b1, 8'h00);
    while (model_q.size() < 9) step("to9_up", 1'b1, 1'b0, 8'($urandom));
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h77;
    @(posedge bclk);
    #3 rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_q.delete();
    exp_rd_data  = 8'h00;
    exp_rd_valid = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
`endif
    #1;
    check_all("async_rst");
    @(posedge bclk);
    #2 rst_n = 1'b1;
    step("post_rst_wr", 1'b1, 1'b0, 8'h5A);
    step("post_rst_rd", 1'b0, 1'b1, 8'h00);
    chk("post_rst_data", 32'(rd_data), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
